// File: rtl/tx_arb_pkg.sv
// rtl/tx_arb_pkg.sv - shared encodings and widths for the TX frame arbiter
package tx_arb_pkg;

  localparam int LEN_W   = 14;
  localparam int CNT_W   = 16;
  localparam int EOF_BIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PASS    = 2'd1,
    ST_DISCARD = 2'd2
  } arb_state_e;

  typedef struct packed {
    arb_state_e        state;
    logic [1:0]        grant;
    logic              last;
    logic [LEN_W-1:0]  len_cnt;
  } arb_ctrl_t;

endpackage

// File: rtl/tx_arb_stat_cnt.sv
// rtl/tx_arb_stat_cnt.sv - wrapping statistics counter with enable
module tx_arb_stat_cnt
  import tx_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tx_frame_arb.sv
// rtl/tx_frame_arb.sv - frame-granular round-robin arbiter in front of the MAC TX FIFO
module tx_frame_arb
  import tx_arb_pkg::*;
#(
  parameter int MAX_LEN = 1500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [8:0]       s0_data,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [8:0]       s1_data,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic             pause,
  output logic [8:0]       txff_din,
  output logic             txff_wren,
  input  logic             txff_afull,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] frame_count0,
  output logic [CNT_W-1:0] frame_count1,
  output logic [CNT_W-1:0] trunc_count
);

  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_LEN - 1);

  arb_ctrl_t  ctrl;
  logic       sel;
  logic [8:0] sel_data;
  logic       sel_valid;
  logic       sel_ready;
  logic       accept;
  logic       beat_eof;
  logic       at_limit;
  logic       pass_accept;
  logic       next_port;
  logic       inc_fc0;
  logic       inc_fc1;
  logic       inc_trunc;

  always_comb begin
    sel       = ctrl.grant[1];
    sel_data  = sel ? s1_data  : s0_data;
    sel_valid = sel ? s1_valid : s0_valid;
    // Discard drains the source regardless of FIFO level since nothing is written.
    case (ctrl.state)
      ST_PASS:    sel_ready = ~txff_afull;
      ST_DISCARD: sel_ready = 1'b1;
      default:    sel_ready = 1'b0;
    endcase
    s0_ready    = sel_ready & ctrl.grant[0];
    s1_ready    = sel_ready & ctrl.grant[1];
    accept      = sel_valid & sel_ready;
    beat_eof    = sel_data[EOF_BIT];
    at_limit    = (ctrl.len_cnt == LAST_IDX);
    pass_accept = (ctrl.state == ST_PASS) & accept;
    next_port   = (s0_valid & s1_valid) ? ~ctrl.last : s1_valid;
    inc_fc0     = pass_accept & beat_eof & ~sel;
    inc_fc1     = pass_accept & beat_eof & sel;
    inc_trunc   = pass_accept & ~beat_eof & at_limit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl.state   <= ST_IDLE;
      ctrl.grant   <= 2'b00;
      ctrl.last    <= 1'b1;
      ctrl.len_cnt <= '0;
      txff_din     <= '0;
      txff_wren    <= 1'b0;
    end else begin
      txff_wren <= 1'b0;
      case (ctrl.state)
        ST_IDLE: begin
          if (!pause && (s0_valid || s1_valid)) begin
            ctrl.grant   <= next_port ? 2'b10 : 2'b01;
            ctrl.last    <= next_port;
            ctrl.len_cnt <= '0;
            ctrl.state   <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (accept) begin
            ctrl.len_cnt <= ctrl.len_cnt + LEN_W'(1);
            txff_wren    <= 1'b1;
            txff_din     <= {beat_eof | at_limit, sel_data[7:0]};
            if (beat_eof) begin
              ctrl.grant <= 2'b00;
              ctrl.state <= ST_IDLE;
            end else if (at_limit) begin
              ctrl.state <= ST_DISCARD;
            end
          end
        end
        ST_DISCARD: begin
          if (accept && beat_eof) begin
            ctrl.grant <= 2'b00;
            ctrl.state <= ST_IDLE;
          end
        end
        default: ctrl.state <= ST_IDLE;
      endcase
    end
  end

  assign grant = ctrl.grant;

  tx_arb_stat_cnt u_fc0 (.clk(clk), .reset(reset), .en(inc_fc0),   .count(frame_count0));
  tx_arb_stat_cnt u_fc1 (.clk(clk), .reset(reset), .en(inc_fc1),   .count(frame_count1));
  tx_arb_stat_cnt u_trc (.clk(clk), .reset(reset), .en(inc_trunc), .count(trunc_count));

endmodule

// File: tb/tb_tx_frame_arb.sv
// tb/tb_tx_frame_arb.sv - randomized scoreboard bench for tx_frame_arb
module tb_tx_frame_arb;

  localparam int MAX_LEN = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  s0_data, s1_data;
  logic        s0_valid, s1_valid;
  logic        s0_ready, s1_ready;
  logic        pause;
  logic [8:0]  txff_din;
  logic        txff_wren;
  logic        txff_afull;
  logic [1:0]  grant;
  logic [15:0] frame_count0, frame_count1, trunc_count;

  tx_frame_arb #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .pause(pause),
    .txff_din(txff_din), .txff_wren(txff_wren), .txff_afull(txff_afull),
    .grant(grant),
    .frame_count0(frame_count0), .frame_count1(frame_count1), .trunc_count(trunc_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int first_wr_cyc = -1;
  int exp_fc0 = 0, exp_fc1 = 0, exp_tr = 0;
  int seq0 = 0, seq1 = 0;
  bit flush = 0;
  bit afull_mode = 0;
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  int gseq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input int p, input logic v, input logic [8:0] d);
    if (p == 0) begin s0_valid = v; s0_data = d; end
    else        begin s1_valid = v; s1_data = d; end
  endtask

  // Reference: the FIFO sees min(len, MAX_LEN) bytes, the last of them marked EOF.
  task automatic send_frame(input int p, input int len, input int gap_max);
    logic [8:0] beats[$];
    logic [8:0] b;
    int s;
    int n;
    bit fire;
    for (int i = 0; i < len; i++) begin
      s = (p == 0) ? seq0 : seq1;
      b = {(i == len - 1), p[0], s[6:0]};
      beats.push_back(b);
      if (i < MAX_LEN) begin
        b[8] = (i == len - 1) || (i == MAX_LEN - 1);
        if (p == 0) exp_q0.push_back(b); else exp_q1.push_back(b);
      end
      if (p == 0) seq0++; else seq1++;
    end
    if (len <= MAX_LEN) begin
      if (p == 0) exp_fc0++; else exp_fc1++;
    end else begin
      exp_tr++;
    end
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        drive(p, 1'b0, 9'h0);
        @(posedge clk); #1;
      end
      drive(p, 1'b1, beats[i]);
      fire = 0;
      n = 0;
      while (!fire) begin
        @(negedge clk);
        if (flush) begin
          drive(p, 1'b0, 9'h0);
          return;
        end
        fire = (p == 0) ? (s0_valid && s0_ready) : (s1_valid && s1_ready);
        n++;
        if (n > 3000) begin
          total++;
          $display("FAIL beat_accept_timeout: port %0d beat %0d never accepted", p, i);
          drive(p, 1'b0, 9'h0);
          return;
        end
        @(posedge clk); #1;
      end
    end
    drive(p, 1'b0, 9'h0);
  endtask

  // Monitor: pops the expected beat for the port tagged in bit 7 of every write.
  initial begin : monitor
    logic [8:0] e;
    logic [1:0] prev_grant;
    bit prev_afull;
    bit in_frame;
    int cur_port;
    int p;
    prev_grant = 0; prev_afull = 0; in_frame = 0; cur_port = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_grant = 0;
        in_frame = 0;
      end else begin
        if (txff_wren) begin
          p = int'(txff_din[7]);
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
          check("no_write_after_afull_window", prev_afull, 0);
          if (in_frame) check("no_interleave", p, cur_port);
          if (p == 0) begin
            check("write_expected_p0", exp_q0.size() > 0, 1);
            if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); check("din_p0", txff_din, e); end
          end else begin
            check("write_expected_p1", exp_q1.size() > 0, 1);
            if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); check("din_p1", txff_din, e); end
          end
          in_frame = !txff_din[8];
          cur_port = p;
        end
        if (grant != prev_grant) begin
          check("grant_onehot", $countones(grant) <= 1, 1);
          if (grant != 0) begin
            check("idle_gap_before_grant", prev_grant, 0);
            gseq.push_back(int'(grant[1]));
          end
        end
        prev_grant = grant;
      end
      prev_afull = txff_afull;
    end
  end

  initial begin : afull_gen
    txff_afull = 0;
    forever begin
      @(posedge clk); #1;
      if (afull_mode) begin
        if (cyc % 3 == 0) txff_afull = ~txff_afull;
      end else begin
        txff_afull = 0;
      end
    end
  end

  task automatic check_counters();
    check("frame_count0", frame_count0, exp_fc0 & 16'hFFFF);
    check("frame_count1", frame_count1, exp_fc1 & 16'hFFFF);
    check("trunc_count", trunc_count, exp_tr & 16'hFFFF);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || grant != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", exp_q0.size() + exp_q1.size(), 0);
    repeat (2) @(negedge clk);
    check_counters();
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", grant, 0);
    check("rst_wren", txff_wren, 0);
    check("rst_din", txff_din, 0);
    check("rst_s0_ready", s0_ready, 0);
    check("rst_s1_ready", s1_ready, 0);
    check("rst_fc0", frame_count0, 0);
    check("rst_fc1", frame_count1, 0);
    check("rst_trunc", trunc_count, 0);
  endtask

  initial begin : stim
    int t0;
    int n;
    reset = 1; pause = 0;
    s0_valid = 0; s1_valid = 0; s0_data = 0; s1_data = 0;
    repeat (3) @(posedge clk); #1;
    check_reset_outputs();
    reset = 0;
    @(posedge clk); #1;

    // Ties after reset alternate starting with port 0; 64-byte frames are exactly MAX_LEN.
    gseq.delete();
    fork
      begin for (int k = 0; k < 3; k++) send_frame(0, MAX_LEN, 0); end
      begin for (int k = 0; k < 3; k++) send_frame(1, MAX_LEN, 0); end
    join
    wait_drain();
    check("tie_grant_count", gseq.size(), 6);
    for (int k = 0; k < 6 && k < gseq.size(); k++) check("tie_grant_order", gseq[k], k % 2);

    // Single frame latency: valid in cycle N, write visible in cycle N+2.
    @(posedge clk); #1;
    t0 = cyc;
    first_wr_cyc = -1;
    send_frame(0, 60, 0);
    wait_drain();
    check("first_write_latency", first_wr_cyc - t0, 2);

    // Length boundaries and truncation.
    send_frame(1, 100, 0);
    wait_drain();
    send_frame(0, MAX_LEN + 1, 1);
    send_frame(0, 1, 0);
    send_frame(1, MAX_LEN - 1, 2);
    wait_drain();

    // Pause with both ports waiting holds off any grant.
    pause = 1;
    fork
      send_frame(0, 10, 0);
      send_frame(1, 10, 0);
      begin
        repeat (20) begin @(negedge clk); check("grant_held_by_pause", grant, 0); end
        @(posedge clk); #1;
        pause = 0;
      end
    join
    wait_drain();

    // Pause raised mid-frame lets that frame finish, then blocks the next one.
    fork
      send_frame(0, 30, 0);
      begin
        n = 0;
        while (grant == 0 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        pause = 1;
      end
    join
    repeat (3) @(negedge clk);
    check("paused_frame_finished", exp_q0.size(), 0);
    fork
      send_frame(1, 10, 0);
      begin
        repeat (10) begin @(negedge clk); check("no_grant_after_pause", grant, 0); end
        @(posedge clk); #1;
        pause = 0;
      end
    join
    wait_drain();

    // Random traffic under toggling back-pressure.
    afull_mode = 1;
    for (int r = 0; r < 4; r++) begin
      fork
        begin for (int k = 0; k < 4; k++) send_frame(0, $urandom_range(1, 100), 3); end
        begin for (int k = 0; k < 4; k++) send_frame(1, $urandom_range(1, 100), 3); end
      join
      wait_drain();
    end
    afull_mode = 0;
    @(posedge clk); #1;

    // Reset mid-frame clears everything at once; next tie goes to port 0.
    fork
      send_frame(0, 50, 0);
      begin
        repeat (15) @(posedge clk);
        #1;
        flush = 1;
        reset = 1;
        #1;
        check_reset_outputs();
      end
    join
    @(posedge clk); #1;
    exp_q0.delete(); exp_q1.delete();
    exp_fc0 = 0; exp_fc1 = 0; exp_tr = 0;
    flush = 0;
    reset = 0;
    gseq.delete();
    @(posedge clk); #1;
    fork
      send_frame(0, 8, 0);
      send_frame(1, 8, 0);
    join
    wait_drain();
    check("post_reset_grant_count", gseq.size(), 2);
    if (gseq.size() > 0) check("post_reset_first_grant", gseq[0], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
